// File: rtl/camerica_video_pkg.sv
// Shared pattern-mode encoding and LFSR constants for the camerica video blocks.
package camerica_video_pkg;

    localparam int PIX_W   = 12;
    localparam int COUNT_W = 16;

    // Feedback mask for x^12+x^6+x^4+x+1; the x^12 term is the bit shifted out.
    localparam logic [PIX_W-1:0] LFSR_POLY = 12'h053;
    localparam logic [PIX_W-1:0] LFSR_SEED = 12'hACE;

    typedef enum logic [1:0] {
        PAT_HRAMP = 2'd0,
        PAT_VRAMP = 2'd1,
        PAT_CONST = 2'd2,
        PAT_LFSR  = 2'd3
    } pat_mode_t;

    function automatic logic [PIX_W-1:0] lfsr_next(input logic [PIX_W-1:0] s);
        return {s[PIX_W-2:0], 1'b0} ^ (s[PIX_W-1] ? LFSR_POLY : '0);
    endfunction

endpackage

// File: rtl/video_pattern_gen_if.sv
// Control inputs and video outputs of the pattern generator, bundled as one port.
interface video_pattern_gen_if;
    import camerica_video_pkg::*;

    logic               en;
    logic [1:0]         mode;
    logic [PIX_W-1:0]   const_value;

    // Stream has no back-pressure: vid_pixsync is a one-clock qualifier and every
    // other vid_* level holds its value from one pixsync to the next.
    logic [PIX_W-1:0]   vid_pixel;
    logic               vid_pixsync;
    logic               vid_hblank;
    logic               vid_vblank;
    logic               vid_visible;
    logic [COUNT_W-1:0] frame_count;
    logic               frame_done;

    modport master (
        input  en, mode, const_value,
        output vid_pixel, vid_pixsync, vid_hblank, vid_vblank, vid_visible,
        output frame_count, frame_done
    );

    modport slave (
        output en, mode, const_value,
        input  vid_pixel, vid_pixsync, vid_hblank, vid_vblank, vid_visible,
        input  frame_count, frame_done
    );

endinterface

// File: rtl/pattern_lfsr.sv
// 12-bit Galois LFSR; load restarts from the seed and may step in the same clock.
module pattern_lfsr
    import camerica_video_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    output logic [PIX_W-1:0] state
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= LFSR_SEED;
        end else if (load && step) begin
            state <= lfsr_next(LFSR_SEED);
        end else if (load) begin
            state <= LFSR_SEED;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/video_pattern_gen.sv
// Video timing and test-pattern generator: one pixel slot every PIX_DIV clocks,
// with run/pattern settings captured only at the top-left slot of each frame.
module video_pattern_gen
    import camerica_video_pkg::*;
#(
    parameter int H_ACTIVE = 320,
    parameter int H_BLANK  = 40,
    parameter int V_ACTIVE = 240,
    parameter int V_BLANK  = 8,
    parameter int PIX_DIV  = 4
) (
    input  logic clk,
    input  logic rst,
    video_pattern_gen_if.master bus
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_ACTIVE + V_BLANK;
    localparam int DIV_W   = $clog2(PIX_DIV);
    // Ramps take x[7:0]/y[7:0], so the counters are never narrower than 8 bits.
    localparam int XW = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
    localparam int YW = ($clog2(V_TOTAL) > 8) ? $clog2(V_TOTAL) : 8;

    logic [DIV_W-1:0]   div_q;
    logic [XW-1:0]      x_q;
    logic [YW-1:0]      y_q;
    logic               running_q;
    pat_mode_t          mode_q;
    logic [PIX_W-1:0]   const_q;

    logic [PIX_W-1:0]   pixel_q;
    logic               pixsync_q;
    logic               hblank_q;
    logic               vblank_q;
    logic               visible_q;
    logic               frame_done_q;
    logic [COUNT_W-1:0] frame_count_q;

    logic               tick;
    logic               boundary;
    logic               x_last;
    logic               y_last;
    logic               in_h;
    logic               in_v;
    logic               run_cur;
    logic               vis_cur;
    pat_mode_t          mode_cur;
    logic [PIX_W-1:0]   const_cur;
    logic [PIX_W-1:0]   lfsr_state;
    logic [PIX_W-1:0]   lfsr_cur;
    logic [PIX_W-1:0]   pix_cur;
    logic               load_lfsr;
    logic               step_lfsr;

    assign tick     = (div_q == DIV_W'(PIX_DIV - 1));
    assign boundary = (x_q == '0) && (y_q == '0);
    assign x_last   = (x_q == XW'(H_TOTAL - 1));
    assign y_last   = (y_q == YW'(V_TOTAL - 1));
    assign in_h     = (x_q < XW'(H_ACTIVE));
    assign in_v     = (y_q < YW'(V_ACTIVE));

    // Slot (0,0) already uses the values being latched on that same clock.
    assign run_cur   = boundary ? bus.en : running_q;
    assign mode_cur  = boundary ? pat_mode_t'(bus.mode) : mode_q;
    assign const_cur = boundary ? bus.const_value : const_q;
    assign lfsr_cur  = boundary ? LFSR_SEED : lfsr_state;
    assign vis_cur   = run_cur && in_h && in_v;

    assign load_lfsr = tick && boundary;
    assign step_lfsr = tick && vis_cur;

    pattern_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (load_lfsr),
        .step  (step_lfsr),
        .state (lfsr_state)
    );

    always_comb begin
        pix_cur = '0;
        if (vis_cur) begin
            case (mode_cur)
                PAT_HRAMP: pix_cur = {x_q[7:0], 4'h0};
                PAT_VRAMP: pix_cur = {y_q[7:0], 4'h0};
                PAT_CONST: pix_cur = const_cur;
                PAT_LFSR:  pix_cur = lfsr_cur;
                default:   pix_cur = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            running_q     <= 1'b0;
            mode_q        <= PAT_HRAMP;
            const_q       <= '0;
            pixel_q       <= '0;
            pixsync_q     <= 1'b0;
            hblank_q      <= 1'b1;
            vblank_q      <= 1'b1;
            visible_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            pixsync_q    <= tick;
            frame_done_q <= 1'b0;
            div_q        <= tick ? '0 : div_q + DIV_W'(1);
            if (tick) begin
                if (boundary) begin
                    running_q <= bus.en;
                    mode_q    <= pat_mode_t'(bus.mode);
                    const_q   <= bus.const_value;
                end
                if (x_last) begin
                    x_q <= '0;
                    y_q <= y_last ? '0 : y_q + YW'(1);
                end else begin
                    x_q <= x_q + XW'(1);
                end
                pixel_q   <= pix_cur;
                visible_q <= vis_cur;
                hblank_q  <= !vis_cur;
                vblank_q  <= !(run_cur && in_v);
                if (run_cur && x_last && y_last) begin
                    frame_done_q  <= 1'b1;
                    frame_count_q <= frame_count_q + COUNT_W'(1);
                end
            end
        end
    end

    assign bus.vid_pixel   = pixel_q;
    assign bus.vid_pixsync = pixsync_q;
    assign bus.vid_hblank  = hblank_q;
    assign bus.vid_vblank  = vblank_q;
    assign bus.vid_visible = visible_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen on a small 10x6-slot raster, PIX_DIV=4.
module tb_video_pattern_gen;

    localparam int HA = 8;
    localparam int HB = 2;
    localparam int VA = 4;
    localparam int VB = 2;
    localparam int PD = 4;
    localparam int HT = HA + HB;
    localparam int VT = VA + VB;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    video_pattern_gen_if vif();

    video_pattern_gen #(
        .H_ACTIVE (HA),
        .H_BLANK  (HB),
        .V_ACTIVE (VA),
        .V_BLANK  (VB),
        .PIX_DIV  (PD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // {pixel, pixsync, hblank, vblank, visible}
    function automatic logic [16:0] vid_snap();
        return {vif.vid_pixel, vif.vid_pixsync, vif.vid_hblank, vif.vid_vblank, vif.vid_visible};
    endfunction

    function automatic logic [11:0] gold_lfsr(input logic [11:0] s);
        return {s[10:0], 1'b0} ^ (s[11] ? 12'h053 : 12'h000);
    endfunction

    function automatic int slot_cyc(input int f, input int y, input int x);
        return PD * (1 + f * HT * VT + y * HT + x);
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        cyc = 0;
    endtask

    task automatic goto(input int f, input int y, input int x);
        while (cyc < slot_cyc(f, y, x)) step(1);
    endtask

    task automatic test_reset();
        vif.en = 1'b1;
        vif.mode = 2'd0;
        vif.const_value = 12'h5A5;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            checks++;
            if ({vid_snap(), vif.frame_done, vif.frame_count} !== {12'h000, 4'b0110, 1'b0, 16'h0000}) begin
                errors++;
                $display("FAIL reset_values got=%h exp=%h",
                         {vid_snap(), vif.frame_done, vif.frame_count}, {12'h000, 4'b0110, 1'b0, 16'h0000});
            end
        end
    endtask

    task automatic test_pixsync_timing();
        logic prev;
        logic exp;
        vif.en = 1'b0;
        do_reset();
        prev = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            step(1);
            exp = ((cyc % PD) == 0);
            checks++;
            if (vif.vid_pixsync !== exp) begin
                errors++;
                $display("FAIL pixsync_clk%0d got=%b exp=%b", cyc, vif.vid_pixsync, exp);
            end
            checks++;
            if (prev && vif.vid_pixsync) begin
                errors++;
                $display("FAIL pixsync_adjacent_clk%0d got=11 exp=not both high", cyc);
            end
            prev = vif.vid_pixsync;
        end
    endtask

    task automatic test_hramp();
        logic [16:0] exp;
        vif.en = 1'b1;
        vif.mode = 2'd0;
        do_reset();
        for (int x = 0; x < HT; x++) begin
            goto(0, 0, x);
            if (x < HA) exp = {12'(x * 16), 4'b1001};
            else        exp = {12'h000, 4'b1100};
            checks++;
            if (vid_snap() !== exp) begin
                errors++;
                $display("FAIL hramp_line0_x%0d got=%h exp=%h", x, vid_snap(), exp);
            end
        end
        goto(0, 1, 3);
        step(2);
        checks++;
        if (vid_snap() !== {12'h030, 4'b0001}) begin
            errors++;
            $display("FAIL hramp_hold_mid_slot got=%h exp=%h", vid_snap(), {12'h030, 4'b0001});
        end
        goto(0, 4, 0);
        checks++;
        if (vid_snap() !== {12'h000, 4'b1110}) begin
            errors++;
            $display("FAIL hramp_vblank got=%h exp=%h", vid_snap(), {12'h000, 4'b1110});
        end
        goto(0, 5, 8);
        checks++;
        if ({vif.frame_done, vif.frame_count} !== {1'b0, 16'd0}) begin
            errors++;
            $display("FAIL hramp_before_done got=%h exp=%h", {vif.frame_done, vif.frame_count}, {1'b0, 16'd0});
        end
        goto(0, 5, 9);
        checks++;
        if ({vif.frame_done, vif.frame_count} !== {1'b1, 16'd1}) begin
            errors++;
            $display("FAIL hramp_frame_done got=%h exp=%h", {vif.frame_done, vif.frame_count}, {1'b1, 16'd1});
        end
        step(1);
        checks++;
        if ({vif.frame_done, vif.frame_count} !== {1'b0, 16'd1}) begin
            errors++;
            $display("FAIL hramp_done_one_clock got=%h exp=%h", {vif.frame_done, vif.frame_count}, {1'b0, 16'd1});
        end
    endtask

    task automatic test_const_midframe();
        vif.en = 1'b1;
        vif.mode = 2'd2;
        vif.const_value = 12'hABC;
        do_reset();
        goto(0, 0, 0);
        checks++;
        if (vid_snap() !== {12'hABC, 4'b1001}) begin
            errors++;
            $display("FAIL const_first got=%h exp=%h", vid_snap(), {12'hABC, 4'b1001});
        end
        vif.mode = 2'd0;
        vif.const_value = 12'h123;
        goto(0, 1, 8);
        checks++;
        if (vid_snap() !== {12'h000, 4'b1100}) begin
            errors++;
            $display("FAIL const_hblank got=%h exp=%h", vid_snap(), {12'h000, 4'b1100});
        end
        goto(0, 2, 5);
        checks++;
        if (vif.vid_pixel !== 12'hABC) begin
            errors++;
            $display("FAIL const_mid got=%h exp=%h", vif.vid_pixel, 12'hABC);
        end
        goto(0, 3, 7);
        checks++;
        if (vif.vid_pixel !== 12'hABC) begin
            errors++;
            $display("FAIL const_last_visible got=%h exp=%h", vif.vid_pixel, 12'hABC);
        end
        goto(1, 0, 3);
        checks++;
        if (vif.vid_pixel !== 12'h030) begin
            errors++;
            $display("FAIL const_next_frame_ramp_x3 got=%h exp=%h", vif.vid_pixel, 12'h030);
        end
        goto(1, 2, 5);
        checks++;
        if (vif.vid_pixel !== 12'h050) begin
            errors++;
            $display("FAIL const_next_frame_ramp_x5 got=%h exp=%h", vif.vid_pixel, 12'h050);
        end
    endtask

    task automatic test_lfsr();
        logic [11:0] model;
        logic [11:0] hand[4];
        int          idx;
        hand[0] = 12'hACE;
        hand[1] = 12'h5CF;
        hand[2] = 12'hB9E;
        hand[3] = 12'h76F;
        vif.en = 1'b1;
        vif.mode = 2'd3;
        do_reset();
        for (int f = 0; f < 2; f++) begin
            model = 12'hACE;
            idx = 0;
            for (int y = 0; y < VA; y++) begin
                for (int x = 0; x < HA; x++) begin
                    if (f == 0 || idx < 4) begin
                        goto(f, y, x);
                        checks++;
                        if (vif.vid_pixel !== model) begin
                            errors++;
                            $display("FAIL lfsr_f%0d_y%0d_x%0d got=%h exp=%h", f, y, x, vif.vid_pixel, model);
                        end
                        if (idx < 4) begin
                            checks++;
                            if (vif.vid_pixel !== hand[idx]) begin
                                errors++;
                                $display("FAIL lfsr_hand_f%0d_i%0d got=%h exp=%h", f, idx, vif.vid_pixel, hand[idx]);
                            end
                        end
                    end
                    model = gold_lfsr(model);
                    idx++;
                end
            end
        end
    endtask

    task automatic test_disabled();
        vif.en = 1'b0;
        vif.mode = 2'd0;
        do_reset();
        goto(0, 0, 0);
        checks++;
        if (vid_snap() !== {12'h000, 4'b1110}) begin
            errors++;
            $display("FAIL idle_first got=%h exp=%h", vid_snap(), {12'h000, 4'b1110});
        end
        vif.en = 1'b1;
        goto(0, 1, 3);
        checks++;
        if (vid_snap() !== {12'h000, 4'b1110}) begin
            errors++;
            $display("FAIL idle_en_midframe got=%h exp=%h", vid_snap(), {12'h000, 4'b1110});
        end
        goto(0, 5, 9);
        checks++;
        if ({vif.frame_done, vif.frame_count} !== {1'b0, 16'd0}) begin
            errors++;
            $display("FAIL idle_no_done got=%h exp=%h", {vif.frame_done, vif.frame_count}, {1'b0, 16'd0});
        end
        goto(1, 0, 2);
        checks++;
        if (vid_snap() !== {12'h020, 4'b1001}) begin
            errors++;
            $display("FAIL idle_next_frame_runs got=%h exp=%h", vid_snap(), {12'h020, 4'b1001});
        end
        goto(1, 5, 9);
        checks++;
        if ({vif.frame_done, vif.frame_count} !== {1'b1, 16'd1}) begin
            errors++;
            $display("FAIL idle_next_frame_done got=%h exp=%h", {vif.frame_done, vif.frame_count}, {1'b1, 16'd1});
        end
    endtask

    task automatic test_count_wrap();
        vif.en = 1'b1;
        vif.mode = 2'd0;
        do_reset();
        goto(0, 2, 0);
        force dut.frame_count_q = 16'hFFFF;
        step(1);
        release dut.frame_count_q;
        goto(0, 5, 8);
        checks++;
        if ({vif.frame_done, vif.frame_count} !== {1'b0, 16'hFFFF}) begin
            errors++;
            $display("FAIL wrap_preload got=%h exp=%h", {vif.frame_done, vif.frame_count}, {1'b0, 16'hFFFF});
        end
        goto(0, 5, 9);
        checks++;
        if ({vif.frame_done, vif.frame_count} !== {1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL wrap_to_zero got=%h exp=%h", {vif.frame_done, vif.frame_count}, {1'b1, 16'h0000});
        end
    endtask

    task automatic test_midline_reset();
        vif.en = 1'b1;
        vif.mode = 2'd0;
        do_reset();
        goto(0, 1, 4);
        checks++;
        if (vif.vid_pixel !== 12'h040) begin
            errors++;
            $display("FAIL midrst_before got=%h exp=%h", vif.vid_pixel, 12'h040);
        end
        step(1);
        rst = 1'b0;
        step(1);
        checks++;
        if ({vid_snap(), vif.frame_done, vif.frame_count} !== {12'h000, 4'b0110, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL midrst_values got=%h exp=%h",
                     {vid_snap(), vif.frame_done, vif.frame_count}, {12'h000, 4'b0110, 1'b0, 16'h0000});
        end
        rst = 1'b1;
        cyc = 0;
        goto(0, 0, 0);
        checks++;
        if (vid_snap() !== {12'h000, 4'b1001}) begin
            errors++;
            $display("FAIL midrst_restart_x0 got=%h exp=%h", vid_snap(), {12'h000, 4'b1001});
        end
        goto(0, 0, 1);
        checks++;
        if (vid_snap() !== {12'h010, 4'b1001}) begin
            errors++;
            $display("FAIL midrst_restart_x1 got=%h exp=%h", vid_snap(), {12'h010, 4'b1001});
        end
        while (cyc < slot_cyc(0, 5, 9) - 2) step(1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            checks++;
            if ({vif.frame_done, vif.frame_count} !== {1'b0, 16'd0}) begin
                errors++;
                $display("FAIL endrst_no_done_%0d got=%h exp=%h", i, {vif.frame_done, vif.frame_count}, {1'b0, 16'd0});
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        vif.en = 1'b0;
        vif.mode = 2'd0;
        vif.const_value = 12'h000;
        test_reset();
        test_pixsync_timing();
        test_hramp();
        test_const_midframe();
        test_lfsr();
        test_disabled();
        test_count_wrap();
        test_midline_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
